data_memory_map: RTL

Memory-mapped data-memory subsystem that sits directly downstream of `system_top` on its RAM port. It consumes `addressM`/`outM`/`writeM` and returns `inM`. It decodes a data RAM, a byte-stream console transmit FIFO and a free-running cycle timer. The console FIFO gives software a buffered output channel drained by an external ready/valid consumer.

---
 rtl/data_memory_map_if.sv | 20 ++
 rtl/data_memory_map.sv | 115 +++++++++++
 2 files changed

// File: rtl/data_memory_map_if.sv
// CPU data-port and console byte-stream signals shared by data_memory_map and its users.
interface data_memory_map_if;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addressM, outM, writeM, tx_ready,
        input  inM, tx_data, tx_valid
    );

    modport slave (
        input  addressM, outM, writeM, tx_ready,
        output inM, tx_data, tx_valid
    );
endinterface

// File: rtl/data_memory_map.sv
// Data-memory decoder: word RAM, console TX byte FIFO with sticky overflow,
// and a loadable free-running cycle timer, all behind a zero-latency read port.
module data_memory_map #(
    parameter int unsigned RAM_WORDS  = 16384,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    data_memory_map_if.slave bus
);
    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [15:0] ADDR_CON_DATA   = 16'h6000;
    localparam logic [15:0] ADDR_CON_STATUS = 16'h6001;
    localparam logic [15:0] ADDR_TIMER      = 16'h6002;
    localparam logic [15:0] ADDR_TIMER_CTRL = 16'h6003;

    logic [15:0]   ram      [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          run;
    logic [15:0]   timer;

    logic          ram_sel_c;
    logic [AW-1:0] ram_idx_c;
    logic          empty_c;
    logic          full_c;
    logic          pop_c;
    logic          push_req_c;
    logic          push_ok_c;
    logic          timer_wr_c;
    logic [15:0]   status_c;
    logic [15:0]   rd_data_c;

    // Address decode and FIFO accept logic
    assign ram_sel_c  = 32'(bus.addressM) < RAM_WORDS;
    assign ram_idx_c  = bus.addressM[AW-1:0];
    assign empty_c    = (count == CW'(0));
    assign full_c     = (count == CW'(FIFO_DEPTH));
    assign pop_c      = !empty_c && bus.tx_ready;
    assign push_req_c = bus.writeM && (bus.addressM == ADDR_CON_DATA);
    assign push_ok_c  = push_req_c && (!full_c || pop_c);
    assign timer_wr_c = bus.writeM && (bus.addressM == ADDR_TIMER);
    assign status_c   = {7'd0, 5'(count), 1'b0, overflow, full_c, empty_c};

    // Storage arrays carry no reset; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && bus.writeM && ram_sel_c) begin
            ram[ram_idx_c] <= bus.outM;
        end
        if (rst && push_ok_c) begin
            fifo_mem[wr_ptr] <= bus.outM[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            run      <= 1'b0;
            timer    <= 16'h0000;
        end else begin
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req_c && !push_ok_c) begin
                overflow <= 1'b1;
            end else if (bus.writeM && (bus.addressM == ADDR_CON_STATUS) && bus.outM[2]) begin
                overflow <= 1'b0;
            end
            if (bus.writeM && (bus.addressM == ADDR_TIMER_CTRL)) begin
                run <= bus.outM[0];
            end
            // A load wins over the increment in the same cycle
            if (timer_wr_c) begin
                timer <= bus.outM;
            end else if (run) begin
                timer <= timer + 16'd1;
            end
        end
    end

    always_comb begin
        rd_data_c = 16'h0000;
        if (ram_sel_c) begin
            rd_data_c = ram[ram_idx_c];
        end else begin
            case (bus.addressM)
                ADDR_CON_STATUS: rd_data_c = status_c;
                ADDR_TIMER:      rd_data_c = timer;
                ADDR_TIMER_CTRL: rd_data_c = {15'd0, run};
                default:         rd_data_c = 16'h0000;
            endcase
        end
    end

    assign bus.inM      = rd_data_c;
    assign bus.tx_data  = fifo_mem[rd_ptr];
    assign bus.tx_valid = !empty_c;
endmodule
